isr_sequencer: RTL and testbench
================================

ISR_SEQUENCER -- requirements
Module: isr_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port clr  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port i_pending  input  1  masked interrupt pending from the interrupt system.
REQ-004 SHALL have port isr_vec  input  8  ISR address from the interrupt system PC mux.
REQ-005 SHALL have port pc_cur  input  8  address of the next instruction to execute.
REQ-006 SHALL have port acc_in  input  8  current accumulator value.
REQ-007 SHALL have port instr_boundary  input  1  high for one cycle when an instruction retires.
REQ-008 SHALL have port rti  input  1  return-from-interrupt decoded; qualified by instr_boundary.
REQ-009 SHALL have ports gie_set and gie_clr  input  1 each  software global-interrupt-enable set and clear.
REQ-010 SHALL have port itr_en  output  1  enable to the interrupt system.
REQ-011 SHALL have port itr_clr  output  1  one-cycle clear of pending interrupts.
REQ-012 SHALL have ports pc_load (output, 1) and pc_next (output, 8): PC overwrite strobe and value.
REQ-013 SHALL have ports acc_load (output, 1) and acc_restore (output, 8): accumulator overwrite strobe and value.
REQ-014 SHALL have ports stall (output, 1), in_isr (output, 1) and isr_count (output, 8): fetch stall, ISR-active flag, and taken-interrupt count.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, SAVE, VECTOR, ISR, RESTORE; all outputs decode from the state and registers only.
REQ-016 SHALL hold a gie register: gie_clr wins over gie_set when both are high; gie_set/gie_clr take effect only in IDLE and ISR.
REQ-017 SHALL drive itr_en = gie in IDLE and itr_en = 0 in every other state.
REQ-018 IDLE->SAVE SHALL occur when i_pending && gie && instr_boundary; isr_vec SHALL be latched into vec_q on that edge.
REQ-019 SAVE SHALL capture pc_cur into saved_pc and acc_in into saved_acc, assert stall, and advance unconditionally to VECTOR.
REQ-020 VECTOR SHALL assert pc_load=1, pc_next=vec_q, itr_clr=1 and stall=1 for exactly one cycle, increment isr_count (saturating at 8'hFF), then go to ISR.
REQ-021 ISR SHALL assert in_isr=1 and stall=0; rti && instr_boundary SHALL move to RESTORE; i_pending SHALL be ignored, so there is no nesting.
REQ-022 RESTORE SHALL assert pc_load=1, pc_next=saved_pc, acc_load=1, acc_restore=saved_acc and stall=1 for one cycle, then go to IDLE.
REQ-023 rti received in IDLE SHALL be ignored.
REQ-024 Latency SHALL be: qualifying edge N leads to pc_load high in cycle N+2; rti edge M leads to restore pc_load in cycle M+1.
REQ-025 When not in VECTOR or RESTORE, pc_load and acc_load SHALL be 0, and pc_next and acc_restore SHALL be 8'h00.
REQ-026 A rising i_pending without instr_boundary SHALL NOT leave IDLE.

Reset
REQ-027 clr high SHALL immediately force IDLE and clear gie, vec_q, saved_pc, saved_acc and isr_count to 0; all outputs SHALL be 0, including during mid-sequence reset.
REQ-028 After reset, interrupts SHALL remain disabled until gie_set.

Structure
REQ-029 State encodings (3-bit) and the ISR_COUNT_MAX constant (8'hFF) SHALL reside in the shared processor package.
REQ-030 The block SHALL be a single module with no sub-modules; the saturating counter is inline.

Verification
REQ-031 gie_set; i_pending=1, isr_vec=8'hD7, pc_cur=8'h12, acc_in=8'h5A, instr_boundary pulse -> 2 cycles later pc_load=1, pc_next=D7, itr_clr=1; isr_count=1.
REQ-032 Continuing: rti with instr_boundary -> next cycle pc_next=8'h12, acc_restore=8'h5A, pc_load=acc_load=1; state IDLE, itr_en=1.
REQ-033 gie=0, i_pending=1, instr_boundary pulses -> no pc_load, itr_en=0; gie_set and gie_clr same cycle -> gie stays 0.
REQ-034 In ISR, i_pending=1 with instr_boundary -> no vectoring; rti in IDLE -> no pc_load.
REQ-035 clr asserted during VECTOR -> outputs 0 asynchronously, isr_count=0, IDLE on release.
REQ-036 256 interrupt entry/exit cycles -> isr_count holds 8'hFF.

Source files
------------

// File: rtl/isr_sequencer_pkg.sv
// rtl/isr_sequencer_pkg.sv - shared processor package: ISR sequencer state encodings and limits
// Purpose: state encoding and count limit used by isr_sequencer.
// Ports: none (package).
package isr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_ISR     = 3'd3,
    ST_RESTORE = 3'd4
  } isr_state_e;

  localparam logic [7:0] ISR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/isr_sequencer.sv
// rtl/isr_sequencer.sv - interrupt entry/exit sequencer with context save and restore
// Purpose: Moore FSM that takes a pending interrupt at an instruction boundary,
//   saves PC/accumulator, vectors to the ISR, and restores context on rti.
// Ports:
//   clk, clr                    clock, asynchronous active-high reset
//   i_pending, isr_vec          masked pending interrupt and its ISR address
//   pc_cur, acc_in              context to save on entry
//   instr_boundary, rti         instruction retire strobe, return-from-interrupt
//   gie_set, gie_clr            software global interrupt enable control
//   itr_en, itr_clr             enable and one-cycle pending clear to interrupt system
//   pc_load, pc_next            PC overwrite strobe and value
//   acc_load, acc_restore       accumulator overwrite strobe and value
//   stall, in_isr, isr_count    fetch stall, ISR-active flag, taken-interrupt count
module isr_sequencer
  import isr_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       i_pending,
  input  logic [7:0] isr_vec,
  input  logic [7:0] pc_cur,
  input  logic [7:0] acc_in,
  input  logic       instr_boundary,
  input  logic       rti,
  input  logic       gie_set,
  input  logic       gie_clr,
  output logic       itr_en,
  output logic       itr_clr,
  output logic       pc_load,
  output logic [7:0] pc_next,
  output logic       acc_load,
  output logic [7:0] acc_restore,
  output logic       stall,
  output logic       in_isr,
  output logic [7:0] isr_count
);

  isr_state_e state_q, state_d;
  logic       gie_q, gie_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] saved_pc_q, saved_pc_d;
  logic [7:0] saved_acc_q, saved_acc_d;
  logic [7:0] isr_count_q, isr_count_d;

  // State register and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      gie_q       <= 1'b0;
      vec_q       <= 8'h00;
      saved_pc_q  <= 8'h00;
      saved_acc_q <= 8'h00;
      isr_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      gie_q       <= gie_d;
      vec_q       <= vec_d;
      saved_pc_q  <= saved_pc_d;
      saved_acc_q <= saved_acc_d;
      isr_count_q <= isr_count_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d     = state_q;
    gie_d       = gie_q;
    vec_d       = vec_q;
    saved_pc_d  = saved_pc_q;
    saved_acc_d = saved_acc_q;
    isr_count_d = isr_count_q;

    // Software may only change gie while not mid-sequence; clear dominates.
    if (state_q == ST_IDLE || state_q == ST_ISR) begin
      if (gie_clr)      gie_d = 1'b0;
      else if (gie_set) gie_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_pending && gie_q && instr_boundary) begin
          state_d = ST_SAVE;
          vec_d   = isr_vec;
        end
      end
      ST_SAVE: begin
        saved_pc_d  = pc_cur;
        saved_acc_d = acc_in;
        state_d     = ST_VECTOR;
      end
      ST_VECTOR: begin
        if (isr_count_q != ISR_COUNT_MAX) isr_count_d = isr_count_q + 8'd1;
        state_d = ST_ISR;
      end
      // i_pending is deliberately not looked at here: no nesting.
      ST_ISR: begin
        if (rti && instr_boundary) state_d = ST_RESTORE;
      end
      ST_RESTORE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore outputs: decode from state and registers only
  always_comb begin
    itr_en      = 1'b0;
    itr_clr     = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 8'h00;
    acc_load    = 1'b0;
    acc_restore = 8'h00;
    stall       = 1'b0;
    in_isr      = 1'b0;
    isr_count   = isr_count_q;

    unique case (state_q)
      ST_IDLE: itr_en = gie_q;
      ST_SAVE: stall = 1'b1;
      ST_VECTOR: begin
        pc_load = 1'b1;
        pc_next = vec_q;
        itr_clr = 1'b1;
        stall   = 1'b1;
      end
      ST_ISR: in_isr = 1'b1;
      ST_RESTORE: begin
        pc_load     = 1'b1;
        pc_next     = saved_pc_q;
        acc_load    = 1'b1;
        acc_restore = saved_acc_q;
        stall       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isr_sequencer.sv
// tb/tb_isr_sequencer.sv - directed self-checking bench for isr_sequencer
module tb_isr_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       i_pending, instr_boundary, rti, gie_set, gie_clr;
  logic [7:0] isr_vec, pc_cur, acc_in;
  logic       itr_en, itr_clr, pc_load, acc_load, stall, in_isr;
  logic [7:0] pc_next, acc_restore, isr_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  isr_sequencer dut (
    .clk(clk), .clr(clr), .i_pending(i_pending), .isr_vec(isr_vec),
    .pc_cur(pc_cur), .acc_in(acc_in), .instr_boundary(instr_boundary),
    .rti(rti), .gie_set(gie_set), .gie_clr(gie_clr), .itr_en(itr_en),
    .itr_clr(itr_clr), .pc_load(pc_load), .pc_next(pc_next),
    .acc_load(acc_load), .acc_restore(acc_restore), .stall(stall),
    .in_isr(in_isr), .isr_count(isr_count)
  );

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; i_pending = 0; instr_boundary = 0; rti = 0; gie_set = 0; gie_clr = 0;
    isr_vec = 8'h00; pc_cur = 8'h00; acc_in = 8'h00;
    step();
    vectors++; if ({itr_en, itr_clr, pc_load, acc_load, stall, in_isr} !== 6'b0) begin
      miscompares++; $display("FAIL reset_strobes got=%b exp=000000", {itr_en, itr_clr, pc_load, acc_load, stall, in_isr}); end
    vectors++; if ({pc_next, acc_restore, isr_count} !== 24'h0) begin
      miscompares++; $display("FAIL reset_values got=%h exp=000000", {pc_next, acc_restore, isr_count}); end
    #2 clr = 1'b0;
    step();
    vectors++; if (itr_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_gie_off got=%b exp=0", itr_en); end
  endtask

  task automatic test_enter_exit();
    gie_set = 1; step(); gie_set = 0;
    vectors++; if (itr_en !== 1'b1) begin miscompares++; $display("FAIL gie_set itr_en got=%b exp=1", itr_en); end
    i_pending = 1; isr_vec = 8'hD7; pc_cur = 8'h12; acc_in = 8'h5A; instr_boundary = 1;
    step(); instr_boundary = 0;
    vectors++; if ({stall, pc_load, itr_en} !== 3'b100) begin
      miscompares++; $display("FAIL save_cycle stall/pc_load/itr_en got=%b exp=100", {stall, pc_load, itr_en}); end
    step();
    vectors++; if ({pc_load, itr_clr, stall, itr_en} !== 4'b1110) begin
      miscompares++; $display("FAIL vector_strobes got=%b exp=1110", {pc_load, itr_clr, stall, itr_en}); end
    vectors++; if (pc_next !== 8'hD7) begin miscompares++; $display("FAIL vector_pc_next got=%h exp=d7", pc_next); end
    pc_cur = 8'h99; acc_in = 8'h33;
    step();
    vectors++; if ({in_isr, stall, pc_load, itr_clr} !== 4'b1000) begin
      miscompares++; $display("FAIL isr_state got=%b exp=1000", {in_isr, stall, pc_load, itr_clr}); end
    vectors++; if (isr_count !== 8'd1) begin miscompares++; $display("FAIL isr_count_one got=%h exp=01", isr_count); end
    vectors++; if (pc_next !== 8'h00) begin miscompares++; $display("FAIL isr_pc_next_idle got=%h exp=00", pc_next); end
    // Pending interrupt at a boundary inside the ISR must not nest.
    instr_boundary = 1; step(); instr_boundary = 0;
    vectors++; if ({in_isr, pc_load, stall} !== 3'b100) begin
      miscompares++; $display("FAIL no_nesting got=%b exp=100", {in_isr, pc_load, stall}); end
    rti = 1; instr_boundary = 1; step(); rti = 0; instr_boundary = 0;
    vectors++; if ({pc_load, acc_load, stall, in_isr} !== 4'b1110) begin
      miscompares++; $display("FAIL restore_strobes got=%b exp=1110", {pc_load, acc_load, stall, in_isr}); end
    vectors++; if ({pc_next, acc_restore} !== 16'h125A) begin
      miscompares++; $display("FAIL restore_values got=%h exp=125a", {pc_next, acc_restore}); end
    step();
    vectors++; if ({itr_en, pc_load, acc_load, in_isr, stall} !== 5'b10000) begin
      miscompares++; $display("FAIL back_to_idle got=%b exp=10000", {itr_en, pc_load, acc_load, in_isr, stall}); end
    // Pending held high without a boundary stays in IDLE.
    repeat (3) step();
    vectors++; if ({stall, pc_load, itr_en} !== 3'b001) begin
      miscompares++; $display("FAIL pending_no_boundary got=%b exp=001", {stall, pc_load, itr_en}); end
    i_pending = 0;
  endtask

  task automatic test_gie_disabled();
    gie_clr = 1; step(); gie_clr = 0;
    vectors++; if (itr_en !== 1'b0) begin miscompares++; $display("FAIL gie_clr itr_en got=%b exp=0", itr_en); end
    i_pending = 1;
    for (int k = 0; k < 3; k++) begin
      instr_boundary = 1; step(); instr_boundary = 0; step();
      vectors++; if ({pc_load, stall, itr_en} !== 3'b000) begin
        miscompares++; $display("FAIL gie_off_no_entry[%0d] got=%b exp=000", k, {pc_load, stall, itr_en}); end
    end
    i_pending = 0;
    gie_set = 1; gie_clr = 1; step(); gie_set = 0; gie_clr = 0;
    vectors++; if (itr_en !== 1'b0) begin miscompares++; $display("FAIL gie_clr_wins got=%b exp=0", itr_en); end
    rti = 1; instr_boundary = 1; step(); rti = 0; instr_boundary = 0;
    vectors++; if ({pc_load, acc_load, stall} !== 3'b000) begin
      miscompares++; $display("FAIL rti_in_idle got=%b exp=000", {pc_load, acc_load, stall}); end
  endtask

  task automatic test_reset_mid();
    gie_set = 1; step(); gie_set = 0;
    i_pending = 1; isr_vec = 8'hA5; instr_boundary = 1; step(); instr_boundary = 0; i_pending = 0;
    step();
    vectors++; if (pc_load !== 1'b1) begin miscompares++; $display("FAIL mid_reset_in_vector got=%b exp=1", pc_load); end
    #2 clr = 1'b1;
    #1;
    vectors++; if ({itr_en, itr_clr, pc_load, acc_load, stall, in_isr} !== 6'b0) begin
      miscompares++; $display("FAIL async_reset_strobes got=%b exp=000000", {itr_en, itr_clr, pc_load, acc_load, stall, in_isr}); end
    vectors++; if ({pc_next, acc_restore, isr_count} !== 24'h0) begin
      miscompares++; $display("FAIL async_reset_values got=%h exp=000000", {pc_next, acc_restore, isr_count}); end
    step();
    clr = 1'b0;
    i_pending = 1; instr_boundary = 1; step(); instr_boundary = 0; i_pending = 0;
    step();
    vectors++; if ({itr_en, stall, pc_load, in_isr} !== 4'b0000) begin
      miscompares++; $display("FAIL post_reset_disabled got=%b exp=0000", {itr_en, stall, pc_load, in_isr}); end
  endtask

  task automatic test_saturation();
    gie_set = 1; step(); gie_set = 0;
    for (int n = 1; n <= 256; n++) begin
      i_pending = 1; instr_boundary = 1; step(); instr_boundary = 0; i_pending = 0;
      step(); step();
      rti = 1; instr_boundary = 1; step(); rti = 0; instr_boundary = 0;
      step();
      if (n == 254) begin
        vectors++; if (isr_count !== 8'hFE) begin miscompares++; $display("FAIL count_254 got=%h exp=fe", isr_count); end
      end
      if (n == 255) begin
        vectors++; if (isr_count !== 8'hFF) begin miscompares++; $display("FAIL count_255 got=%h exp=ff", isr_count); end
      end
    end
    vectors++; if (isr_count !== 8'hFF) begin miscompares++; $display("FAIL count_saturated got=%h exp=ff", isr_count); end
  endtask

  initial begin
    test_reset();
    test_enter_exit();
    test_gie_disabled();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
